// File: rtl/dram_banked.sv
// dram_banked: multi-bank SDRAM-style memory model with per-bank open row, tRCD check and CAS-latency read pipeline
// Ports: CK/RST clock and synchronous active-high reset; CSn/RASn/CASn command strobes; WEn per-byte write enable
//        (active-low); BA bank select; A multiplexed row/column address; D write data; Q/Q_VALID read data and
//        strobe; ERR sticky protocol-error flag; BANK_OPEN per-bank open-row flags.
module dram_banked #(
   parameter int WORD_SIZE = 32,
   parameter int BANK_BITS = 2,
   parameter int ROW_BITS  = 8,
   parameter int COL_BITS  = 8,
   parameter int ADDR_SIZE = 12,
   parameter int CAS_LAT   = 2,
   parameter int T_RCD     = 2
) (
   input  logic                      CK,
   input  logic                      RST,
   input  logic                      CSn,
   input  logic                      RASn,
   input  logic                      CASn,
   input  logic [WORD_SIZE/8-1:0]    WEn,
   input  logic [BANK_BITS-1:0]      BA,
   input  logic [ADDR_SIZE-1:0]      A,
   input  logic [WORD_SIZE-1:0]      D,
   output logic [WORD_SIZE-1:0]      Q,
   output logic                      Q_VALID,
   output logic                      ERR,
   output logic [2**BANK_BITS-1:0]   BANK_OPEN
);
   localparam int LANES     = WORD_SIZE / 8;
   localparam int NUM_BANKS = 2 ** BANK_BITS;
   localparam int IDX_W     = BANK_BITS + ROW_BITS + COL_BITS;

   typedef enum logic [1:0] {CLOSED, OPENING, ACTIVE} bank_st_e;

   logic cmd_act, cmd_rd, cmd_wr, cmd_pre, cmd_pall;
   logic rd_ok, wr_ok, cmd_err;
   logic [NUM_BANKS-1:0] open_v, ready_v;
   logic [NUM_BANKS-1:0][ROW_BITS-1:0] row_v;
   logic [IDX_W-1:0] idx;
   logic [WORD_SIZE-1:0] rd_word;
   logic err_q, err_d;
   logic [CAS_LAT:0] pv_q;
   logic [CAS_LAT:0][WORD_SIZE-1:0] pd_q;
   logic unused_a;

   assign cmd_act  = !CSn && !RASn &&  CASn;
   assign cmd_rd   = !CSn &&  RASn && !CASn &&  (&WEn);
   assign cmd_wr   = !CSn &&  RASn && !CASn && !(&WEn);
   assign cmd_pre  = !CSn && !RASn && !CASn &&  (&WEn);
   assign cmd_pall = !CSn && !RASn && !CASn && ~(|WEn);

   // column commands are legal only once the target bank has finished tRCD
   assign rd_ok   = cmd_rd && ready_v[BA];
   assign wr_ok   = cmd_wr && ready_v[BA];
   assign cmd_err = (cmd_act && open_v[BA]) || ((cmd_rd || cmd_wr) && !ready_v[BA]);
   assign err_d   = err_q || cmd_err;

   assign idx      = {BA, row_v[BA], A[COL_BITS-1:0]};
   assign unused_a = ^A;

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      bank_st_e st_q;
      logic [2:0] cnt_q;
      logic [ROW_BITS-1:0] row_q;
      logic hit;
      assign hit = BA == BANK_BITS'(b);
      // the ACT edge itself counts as the first tRCD cycle, so the counter starts one short
      always_ff @(posedge CK) begin
         if (RST) begin
            st_q  <= CLOSED;
            cnt_q <= '0;
         end else if (cmd_pall || (cmd_pre && hit)) begin
            st_q  <= CLOSED;
            cnt_q <= '0;
         end else if (cmd_act && hit && st_q == CLOSED) begin
            st_q  <= (T_RCD > 1) ? OPENING : ACTIVE;
            cnt_q <= 3'(T_RCD - 1);
            row_q <= A[ROW_BITS-1:0];
         end else if (st_q == OPENING) begin
            cnt_q <= cnt_q - 3'd1;
            if (cnt_q == 3'd1) st_q <= ACTIVE;
         end
      end
      assign open_v[b]  = st_q != CLOSED;
      assign ready_v[b] = st_q == ACTIVE;
      assign row_v[b]   = row_q;
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [7:0] Memory_byte [2**IDX_W];
      always_ff @(posedge CK) begin
         if (!RST && wr_ok && !WEn[k]) Memory_byte[idx] <= D[8*k +: 8];
      end
      assign rd_word[8*k +: 8] = Memory_byte[idx];
   end

   always_ff @(posedge CK) begin
      if (RST) err_q <= 1'b0;
      else     err_q <= err_d;
   end

   // stage 0 captures the array at the READ edge; the last stage only loads on valid data so Q holds
   always_ff @(posedge CK) begin
      if (RST) begin
         pv_q <= '0;
         pd_q <= '0;
      end else begin
         pv_q    <= {pv_q[CAS_LAT-1:0], rd_ok};
         pd_q[0] <= rd_word;
         for (int i = 1; i < CAS_LAT; i++) pd_q[i] <= pd_q[i-1];
         if (pv_q[CAS_LAT-1]) pd_q[CAS_LAT] <= pd_q[CAS_LAT-1];
      end
   end

   assign Q         = pd_q[CAS_LAT];
   assign Q_VALID   = pv_q[CAS_LAT];
   assign ERR       = err_q;
   assign BANK_OPEN = open_v;
endmodule
